sd_sector_arbiter: RTL and testbench

Shares one `sd_controller` instance between two requesters (port 0: CPU loader, port 1: DMA/asset streamer) on a sector basis. Arbitrates round-robin and sequences the controller's rd/wr strobes. Moves the 512 data bytes between the controller's byte stream and an internal sector buffer, which the requesters fill or drain. A watchdog recovers a hung card by pulsing the controller reset.

---
 rtl/sd_arb_pkg.sv | 25 ++
 rtl/sector_buffer.sv | 29 ++
 rtl/sd_sector_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_sd_sector_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_arb_pkg.sv
// Shared types and sizes for the two-port SD sector arbiter.
package sd_arb_pkg;

    localparam int unsigned SECTOR_BYTES = 512;
    localparam int unsigned NUM_PORTS    = 2;
    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned BUF_AW       = $clog2(SECTOR_BYTES);
    localparam int unsigned IDX_W        = BUF_AW + 1;

    typedef enum logic [2:0] {
        ST_RESET_SD,
        ST_WAIT_INIT,
        ST_IDLE,
        ST_ISSUE,
        ST_XFER,
        ST_DONE
    } arb_state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
    } sd_req_t;

endpackage

// File: rtl/sector_buffer.sv
// 512x8 single-port sector RAM with a registered read port.
module sector_buffer
    import sd_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [BUF_AW-1:0] addr,
    input  logic [BYTE_W-1:0] wdata,
    output logic [BYTE_W-1:0] rdata
);

    logic [BYTE_W-1:0] mem [SECTOR_BYTES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sd_sector_arbiter.sv
// Round-robin sector arbiter sharing one SD controller between two ports,
// with an internal sector buffer and a watchdog that resets a hung card.
module sd_sector_arbiter
    import sd_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned SD_RST_CYCLES  = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] we,
    input  logic [ADDR_W-1:0]    addr0,
    input  logic [ADDR_W-1:0]    addr1,
    output logic [NUM_PORTS-1:0] done,
    output logic                 err,
    output logic                 owner,
    output logic                 busy,
    input  logic [BUF_AW-1:0]    buf_addr,
    input  logic [BYTE_W-1:0]    buf_wdata,
    input  logic                 buf_we,
    output logic [BYTE_W-1:0]    buf_rdata,
    output logic                 sd_rd,
    output logic                 sd_wr,
    output logic [ADDR_W-1:0]    sd_address,
    output logic [BYTE_W-1:0]    sd_din,
    input  logic [BYTE_W-1:0]    sd_dout,
    input  logic                 sd_byte_available,
    input  logic                 sd_ready_for_next_byte,
    input  logic                 sd_ready,
    output logic                 sd_reset
);

    localparam int unsigned RST_W = $clog2(SD_RST_CYCLES + 1);
    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_e state, state_nx;

    logic [RST_W-1:0]     rst_cnt, rst_cnt_nx;
    logic [WD_W-1:0]      wdog, wdog_nx;
    logic [IDX_W-1:0]     idx, idx_nx;
    sd_req_t              cur, cur_nx;
    logic                 owner_nx, busy_nx, err_nx;
    logic                 sd_rd_nx, sd_wr_nx, sd_reset_nx;
    logic [NUM_PORTS-1:0] done_nx;
    logic                 bav_q, rfn_q, cmd_seen, cmd_seen_nx;

    logic                 ram_we;
    logic [BUF_AW-1:0]    ram_addr;
    logic [BYTE_W-1:0]    ram_wdata, ram_rdata;

    logic grant, grant_port, in_xfer_phase, timeout, idx_full, bav_rise, rfn_fall, strobe;

    assign grant         = (state == ST_IDLE) && (|req);
    assign grant_port    = req[~owner] ? ~owner : owner;
    assign in_xfer_phase = (state == ST_ISSUE) || (state == ST_XFER);
    assign timeout       = in_xfer_phase && (wdog == WD_W'(TIMEOUT_CYCLES - 1));
    assign idx_full      = (idx == IDX_W'(SECTOR_BYTES));
    assign bav_rise      = sd_byte_available && !bav_q;
    assign rfn_fall      = rfn_q && !sd_ready_for_next_byte;
    assign strobe        = sd_rd || sd_wr;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RESET_SD;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; the watchdog overrides any in-flight transfer
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_RESET_SD:  if (rst_cnt == '0) state_nx = ST_WAIT_INIT;
            ST_WAIT_INIT: if (sd_ready) state_nx = ST_IDLE;
            ST_IDLE:      if (|req) state_nx = ST_ISSUE;
            ST_ISSUE: begin
                if (timeout)                    state_nx = ST_RESET_SD;
                else if (strobe && !sd_ready)   state_nx = ST_XFER;
            end
            ST_XFER: begin
                if (timeout)       state_nx = ST_RESET_SD;
                else if (sd_ready) state_nx = ST_DONE;
            end
            ST_DONE:      state_nx = ST_IDLE;
            default:      state_nx = ST_RESET_SD;
        endcase
    end

    // Output / datapath next values, registered below
    always_comb begin
        rst_cnt_nx  = (state == ST_RESET_SD) ? rst_cnt - RST_W'(1) : RST_W'(SD_RST_CYCLES - 1);
        wdog_nx     = in_xfer_phase ? wdog + WD_W'(1) : '0;
        idx_nx      = idx;
        cmd_seen_nx = cmd_seen;
        cur_nx      = cur;
        owner_nx    = owner;

        if (grant) begin
            idx_nx      = '0;
            cmd_seen_nx = 1'b0;
            owner_nx    = grant_port;
            cur_nx.we   = we[grant_port];
            cur_nx.addr = grant_port ? addr1 : addr0;
        end else if (state == ST_XFER) begin
            if (!cur.we) begin
                if (bav_rise && !idx_full) idx_nx = idx + IDX_W'(1);
            end else if (rfn_fall) begin
                // First pulse belongs to the write command, not to a data byte
                if (!cmd_seen)      cmd_seen_nx = 1'b1;
                else if (!idx_full) idx_nx      = idx + IDX_W'(1);
            end
        end

        busy_nx     = (state_nx == ST_ISSUE) || (state_nx == ST_XFER);
        sd_rd_nx    = (state == ST_ISSUE) && (state_nx == ST_ISSUE) && !cur.we;
        sd_wr_nx    = (state == ST_ISSUE) && (state_nx == ST_ISSUE) && cur.we;
        sd_reset_nx = (state_nx == ST_RESET_SD);

        done_nx = '0;
        err_nx  = 1'b0;
        if (timeout) begin
            done_nx = NUM_PORTS'(1) << owner;
            err_nx  = 1'b1;
        end else if (state_nx == ST_DONE) begin
            done_nx = NUM_PORTS'(1) << owner;
            err_nx  = !cur.we && (idx_nx != IDX_W'(SECTOR_BYTES));
        end

        ram_we    = in_xfer_phase ? ((state == ST_XFER) && !cur.we && bav_rise && !idx_full)
                                  : (buf_we && !busy);
        ram_addr  = in_xfer_phase ? idx[BUF_AW-1:0] : buf_addr;
        ram_wdata = in_xfer_phase ? sd_dout : buf_wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_cnt  <= RST_W'(SD_RST_CYCLES - 1);
            wdog     <= '0;
            idx      <= '0;
            cur      <= '0;
            cmd_seen <= 1'b0;
            bav_q    <= 1'b0;
            rfn_q    <= 1'b0;
            owner    <= 1'b1;
            busy     <= 1'b0;
            done     <= '0;
            err      <= 1'b0;
            sd_rd    <= 1'b0;
            sd_wr    <= 1'b0;
            sd_reset <= 1'b1;
        end else begin
            rst_cnt  <= rst_cnt_nx;
            wdog     <= wdog_nx;
            idx      <= idx_nx;
            cur      <= cur_nx;
            cmd_seen <= cmd_seen_nx;
            bav_q    <= sd_byte_available;
            rfn_q    <= sd_ready_for_next_byte;
            owner    <= owner_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            err      <= err_nx;
            sd_rd    <= sd_rd_nx;
            sd_wr    <= sd_wr_nx;
            sd_reset <= sd_reset_nx;
        end
    end

    assign sd_address = cur.addr;
    assign sd_din     = ram_rdata;
    assign buf_rdata  = ram_rdata;

    sector_buffer u_buf (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Directed bench for sd_sector_arbiter with a behavioural SD controller model.
module tb_sd_sector_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req, we;
    logic [31:0] addr0, addr1;
    logic [1:0]  done;
    logic        err, owner, busy;
    logic [8:0]  buf_addr;
    logic [7:0]  buf_wdata;
    logic        buf_we;
    logic [7:0]  buf_rdata;
    logic        sd_rd, sd_wr;
    logic [31:0] sd_address;
    logic [7:0]  sd_din, sd_dout;
    logic        sd_byte_available, sd_ready_for_next_byte, sd_ready, sd_reset;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_strobe = 0;
    int t_done   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sd_sector_arbiter #(.TIMEOUT_CYCLES(5000), .SD_RST_CYCLES(256)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .req                    (req),
        .we                     (we),
        .addr0                  (addr0),
        .addr1                  (addr1),
        .done                   (done),
        .err                    (err),
        .owner                  (owner),
        .busy                   (busy),
        .buf_addr               (buf_addr),
        .buf_wdata              (buf_wdata),
        .buf_we                 (buf_we),
        .buf_rdata              (buf_rdata),
        .sd_rd                  (sd_rd),
        .sd_wr                  (sd_wr),
        .sd_address             (sd_address),
        .sd_din                 (sd_din),
        .sd_dout                (sd_dout),
        .sd_byte_available      (sd_byte_available),
        .sd_ready_for_next_byte (sd_ready_for_next_byte),
        .sd_ready               (sd_ready),
        .sd_reset               (sd_reset)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_strobe(input string tag, input logic is_wr, input logic [31:0] exp_addr);
        int n = 0;
        while (!sd_rd && !sd_wr && n < 50) begin
            @(negedge clk);
            n++;
        end
        t_strobe = cyc;
        check_eq({tag, "_strobe"}, 32'({sd_wr, sd_rd}), is_wr ? 32'd2 : 32'd1);
        check_eq({tag, "_addr"}, sd_address, exp_addr);
    endtask

    task automatic wait_done(input int limit, output logic [1:0] d, output logic e);
        int n = 0;
        d = 2'b00;
        e = 1'b0;
        while (n < limit) begin
            @(negedge clk);
            n++;
            if (done != 2'b00) begin
                d = done;
                e = err;
                break;
            end
        end
        t_done = cyc;
    endtask

    task automatic stream_bytes(input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            sd_dout           = 8'(i);
            sd_byte_available = 1'b1;
            repeat (3) @(negedge clk);
            sd_byte_available = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic serve_read(input string tag, input logic [31:0] exp_addr, input int nbytes,
                              output logic [1:0] d, output logic e);
        wait_strobe(tag, 1'b0, exp_addr);
        sd_ready = 1'b0;
        repeat (2) @(negedge clk);
        stream_bytes(nbytes);
        sd_ready = 1'b1;
        wait_done(20, d, e);
    endtask

    // Command pulse first, then one pulse per byte; din is captured while the pulse is high
    task automatic serve_write(input string tag, input logic [31:0] exp_addr, input int nbytes,
                               output int bad);
        bad = 0;
        wait_strobe(tag, 1'b1, exp_addr);
        sd_ready = 1'b0;
        repeat (2) @(negedge clk);
        sd_ready_for_next_byte = 1'b1;
        repeat (2) @(negedge clk);
        sd_ready_for_next_byte = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < nbytes; k++) begin
            sd_ready_for_next_byte = 1'b1;
            repeat (2) @(negedge clk);
            if (sd_din !== (8'hA5 ^ 8'(k))) bad++;
            sd_ready_for_next_byte = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL tb_watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] d;
        logic       e;
        int         cnt, bad, nb;

        reset = 1'b0; req = 2'b00; we = 2'b00; addr0 = '0; addr1 = '0;
        buf_addr = '0; buf_wdata = '0; buf_we = 1'b0;
        sd_dout = '0; sd_byte_available = 1'b0; sd_ready_for_next_byte = 1'b0; sd_ready = 1'b0;
        repeat (3) @(negedge clk);

        check_eq("rst_done_err", 32'({done, err}), 32'd0);
        check_eq("rst_owner", 32'(owner), 32'd1);
        check_eq("rst_busy_strobes", 32'({busy, sd_rd, sd_wr}), 32'd0);
        check_eq("rst_sd_reset", 32'(sd_reset), 32'd1);
        check_eq("rst_buf_rdata", 32'(buf_rdata), 32'd0);

        // Card stays not-ready for 1000 cycles; port 0 requests the whole time
        reset = 1'b1;
        req   = 2'b01; we = 2'b00; addr0 = 32'h0000_0400;
        cnt = 0;
        while (cnt < 400) begin
            @(posedge clk);
            cnt++;
            #1;
            if (!sd_reset) break;
        end
        check_eq("sd_reset_len", 32'(cnt), 32'd256);
        @(negedge clk);
        nb = 0;
        repeat (1000 - cnt - 1) begin
            if (busy) nb++;
            @(negedge clk);
        end
        check_eq("no_grant_wait_init", 32'(nb), 32'd0);
        sd_ready = 1'b1;

        // Port 0 reads 512 bytes
        serve_read("rd0", 32'h0000_0400, 512, d, e);
        check_eq("rd0_done", 32'(d), 32'd1);
        check_eq("rd0_err", 32'(e), 32'd0);
        check_eq("rd0_busy_at_done", 32'(busy), 32'd0);
        req = 2'b00;
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            buf_addr = 9'(i);
            @(negedge clk);
            if (buf_rdata !== 8'(i)) bad++;
        end
        check_eq("rd0_buf_bytes_bad", 32'(bad), 32'd0);

        // Port 1 fills the buffer and writes it out
        for (int i = 0; i < 512; i++) begin
            buf_addr  = 9'(i);
            buf_wdata = 8'hA5 ^ 8'(i);
            buf_we    = 1'b1;
            @(negedge clk);
        end
        buf_we = 1'b0;
        req = 2'b10; we = 2'b10; addr1 = 32'h0000_0800;
        @(negedge clk);
        check_eq("wr1_grant_cycle", 32'({busy, sd_wr}), 32'd2);
        check_eq("wr1_owner", 32'(owner), 32'd1);
        @(negedge clk);
        check_eq("wr1_strobe_cycle", 32'({busy, sd_wr}), 32'd3);
        serve_write("wr1", 32'h0000_0800, 512, bad);
        check_eq("wr1_din_bytes_bad", 32'(bad), 32'd0);
        sd_ready = 1'b1;
        wait_done(20, d, e);
        check_eq("wr1_done", 32'(d), 32'd2);
        check_eq("wr1_err", 32'(e), 32'd0);
        req = 2'b00;
        @(negedge clk);

        // Both ports request continuously: strict alternation starting at port 0
        req = 2'b11; we = 2'b00; addr0 = 32'h0000_0400; addr1 = 32'h0000_0800;
        for (int k = 0; k < 4; k++) begin
            logic exp_port;
            exp_port = 1'(k % 2);
            serve_read("rr", exp_port ? 32'h0000_0800 : 32'h0000_0400, 512, d, e);
            check_eq("rr_done", 32'(d), exp_port ? 32'd2 : 32'd1);
            check_eq("rr_owner", 32'(owner), 32'(exp_port));
            check_eq("rr_busy_at_done", 32'(busy), 32'd0);
            if (k == 3) req = 2'b00;
            @(negedge clk);
            check_eq("rr_gap", 32'(busy), 32'd0);
        end

        // Read stalls after 100 bytes: watchdog fires and resets the card
        req = 2'b01; we = 2'b00; addr0 = 32'h0000_1000;
        wait_strobe("to", 1'b0, 32'h0000_1000);
        sd_ready = 1'b0;
        repeat (2) @(negedge clk);
        stream_bytes(100);
        wait_done(6000, d, e);
        check_eq("to_done", 32'(d), 32'd1);
        check_eq("to_err", 32'(e), 32'd1);
        check_eq("to_sd_reset", 32'(sd_reset), 32'd1);
        check_eq("to_latency", 32'(t_done - t_strobe), 32'd4999);
        req = 2'b00;
        cnt = 0;
        while (sd_reset && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        check_eq("to_sd_reset_fall", 32'(sd_reset), 32'd0);
        req = 2'b10; we = 2'b00; addr1 = 32'h0000_2000;
        nb = 0;
        repeat (50) begin
            @(negedge clk);
            if (busy) nb++;
        end
        check_eq("to_wait_init_hold", 32'(nb), 32'd0);
        sd_ready = 1'b1;

        // Short read of 511 bytes on port 1
        serve_read("short", 32'h0000_2000, 511, d, e);
        check_eq("short_done", 32'(d), 32'd2);
        check_eq("short_err", 32'(e), 32'd1);
        req = 2'b00;
        @(negedge clk);

        // Reset asserted in the middle of a write
        req = 2'b01; we = 2'b01; addr0 = 32'h0000_3000;
        serve_write("mw", 32'h0000_3000, 10, bad);
        reset = 1'b0;
        sd_ready_for_next_byte = 1'b0;
        #1;
        check_eq("mw_sd_reset", 32'(sd_reset), 32'd1);
        check_eq("mw_busy_strobes", 32'({busy, sd_rd, sd_wr}), 32'd0);
        nb = 0;
        repeat (4) begin
            @(negedge clk);
            if (done != 2'b00) nb++;
        end
        reset = 1'b1;
        req   = 2'b00;
        repeat (3) begin
            @(negedge clk);
            if (done != 2'b00) nb++;
        end
        check_eq("mw_no_done", 32'(nb), 32'd0);
        check_eq("mw_sd_reset_after", 32'(sd_reset), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
